nobl_rw_scheduler: RTL and testbench
====================================

Name: nobl_rw_scheduler

Overview:
Single-clock scheduler that shares one ZBT/NoBL SRAM port between a write requester (the input CDC FIFO draining toward the SRAM) and a read requester (the output CDC FIFO filling from the SRAM). It owns the circular write and read pointers and the occupancy count. It grants bounded bursts with bus-turnaround cycles, and drives the SRAM address and control strobes. It runs in the ext_clk domain and sits between the two CDC FIFOs.

Parameters:
RAM_DEPTH, 19, SRAM address width.
FIFO_DEPTH, 19, pointer width; FIFO holds at most 2^FIFO_DEPTH-1 words; must be <= RAM_DEPTH.
BURST, 8, max consecutive accesses in one direction before re-arbitration (1..255).
TURNAROUND, 1, idle cycles inserted on write<->read switch (0..3).
READ_LAT, 2, SRAM read pipeline latency in cycles.

Ports:
clk  in  1  ext_clk domain clock
rst  in  1  synchronous, active-high reset
wr_req  in  1  write side has a word (input FIFO not empty)
wr_ack  out  1  word accepted this cycle; pops input FIFO, SRAM write issued
rd_req  in  1  read side can take a word (output FIFO not almost-full)
rd_ack  out  1  SRAM read issued this cycle
rd_valid  out  1  read data on SRAM bus is valid; rd_ack delayed READ_LAT cycles
ram_addr  out  RAM_DEPTH  SRAM address; pointer zero-extended
ram_we  out  1  active-high write enable (inverted into RAM_WEn by pad logic)
ram_en  out  1  active-high access enable (inverted into RAM_CENn)
ram_doe  out  1  data output enable; ram_we delayed 2 cycles (ZBT write data phase)
capacity  out  FIFO_DEPTH  free words
space_avail  out  1  capacity != 0
data_avail  out  1  occupancy != 0

Behaviour:
- Reset: state IDLE; wr_ptr=rd_ptr=0; occupancy=0; capacity=2^FIFO_DEPTH-1; all strobes 0; read and doe pipelines cleared; last_dir=READ, so the first grant prefers WRITE.
- States: IDLE, WRITE, READ, TURN.
- IDLE:
  - Eligible write = wr_req & space_avail. Eligible read = rd_req & data_avail.
  - Both eligible: grant the direction opposite last_dir. One eligible: grant it.
  - Entering a direction whose bus turns differently from last_dir goes via TURN when TURNAROUND>0.
  - Grant takes effect in the next cycle.
- WRITE:
  - Each cycle wr_req & space_avail: wr_ack=ram_en=ram_we=1, ram_addr=wr_ptr, wr_ptr++, occupancy++, burst_cnt++.
  - Leave to IDLE when burst_cnt==BURST, or the condition drops (no stall cycles held in WRITE).
  - last_dir=WRITE on exit.
- READ: mirror of WRITE using rd_req & data_avail, rd_ack, rd_ptr, occupancy--. ram_we=0.
- TURN: counts TURNAROUND cycles with all strobes 0, then enters the granted state. Requests are not re-sampled there; if the request vanished, the target state exits immediately to IDLE.
- Single-cycle accesses: there is never a write and a read in the same cycle, so occupancy changes by at most ±1 per cycle.
- Registered outputs:
  - capacity, space_avail and data_avail are registered from next-state occupancy.
  - An access issued this cycle is reflected next cycle, so full and empty are never overrun.
- Pointers wrap modulo 2^FIFO_DEPTH.
- Full: occupancy = 2^FIFO_DEPTH-1. wr_ack is held 0; read allowed.
- Empty: wr_ack allowed; rd_ack is held 0.
- rd_valid follows rd_ack by exactly READ_LAT cycles, independent of state. rst clears the pipeline, discarding in-flight reads.
- Reset mid-burst: next cycle all outputs are at reset values; stored data is considered lost.

Optional Feature:
SCHED_STATS_EN:
- Defined: adds outputs stat_turns[15:0] (count of TURN entries) and stat_maxocc[FIFO_DEPTH-1:0] (high-water occupancy).
  - Both are saturating and cleared by rst.
- Undefined: the ports and logic are absent.

Decomposition:
- Package nobl_sched_pkg holds:
  - state enum {IDLE, WRITE, READ, TURN};
  - direction enum {DIR_WRITE, DIR_READ};
  - the default BURST, TURNAROUND and READ_LAT constants.
- Sub-module nobl_delay_line (WIDTH, DEPTH, sync reset shift register) is used for rd_valid (DEPTH=READ_LAT) and ram_doe (DEPTH=2).

Test Plan:
- Reset with FIFO_DEPTH=4 -> capacity=15, space_avail=1, data_avail=0, all strobes 0, no ack while only rd_req=1.
- wr_req=1 for 20 cycles, rd_req=0, BURST=8, FIFO_DEPTH=4:
  - 15 wr_acks at addresses 0..14, with one IDLE cycle after every 8;
  - then capacity=0 and wr_ack=0 while full.
- After 5 writes, rd_req=1 alone, TURNAROUND=1:
  - one TURN cycle, then rd_ack at addresses 0..4;
  - rd_valid pulses 2 cycles after each rd_ack;
  - data_avail=0 after the 5th.
- wr_req=rd_req=1 continuously, non-empty, BURST=4: alternating bursts W4,TURN,R4,TURN,...; occupancy is unchanged over each period.
- Pointer wrap with FIFO_DEPTH=3: 10 writes interleaved with reads -> ram_addr sequence 0..7,0,1; occupancy is never above 7.
- rst asserted during the 3rd beat of a read burst -> next cycle state IDLE, rd_ack=0, pending rd_valid pulses suppressed, capacity back to maximum.

Source files
------------

// File: rtl/nobl_sched_pkg.sv
// Shared types and default constants for the NoBL SRAM read/write scheduler.
package nobl_sched_pkg;

  // Default burst length, bus-turnaround gap and SRAM read latency.
  localparam int unsigned BURST_DEFAULT      = 8;
  localparam int unsigned TURNAROUND_DEFAULT = 1;
  localparam int unsigned READ_LAT_DEFAULT   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StTurn
  } state_e;

  typedef enum logic {
    DirWrite,
    DirRead
  } dir_e;

  // Burst state that serves a granted direction.
  function automatic state_e dir_state(dir_e dir);
    return (dir == DirWrite) ? StWrite : StRead;
  endfunction

endpackage

// File: rtl/nobl_delay_line.sv
// Fixed-length shift register with synchronous active-high reset.
// DEPTH = 0 degenerates to a wire.
module nobl_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift din one stage per cycle; reset flushes everything in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/nobl_rw_scheduler.sv
// Shares one ZBT/NoBL SRAM port between a write requester and a read requester.
// Owns circular pointers and occupancy, grants bounded bursts with turnaround gaps.
// Optional build macro SCHED_STATS_EN adds turn-count and high-water statistics ports.
module nobl_rw_scheduler
  import nobl_sched_pkg::*;
#(
  parameter int unsigned RAM_DEPTH  = 19,
  parameter int unsigned FIFO_DEPTH = 19,
  parameter int unsigned BURST      = BURST_DEFAULT,
  parameter int unsigned TURNAROUND = TURNAROUND_DEFAULT,
  parameter int unsigned READ_LAT   = READ_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [RAM_DEPTH-1:0]  ram_addr,
  output logic                  ram_we,
  output logic                  ram_en,
  output logic                  ram_doe,
  output logic [FIFO_DEPTH-1:0] capacity,
  output logic                  space_avail,
  output logic                  data_avail
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]           stat_turns,
  output logic [FIFO_DEPTH-1:0] stat_maxocc
`endif
);

  localparam logic [FIFO_DEPTH-1:0] OccMax    = '1;
  localparam logic [FIFO_DEPTH-1:0] PtrOne    = FIFO_DEPTH'(1);
  localparam logic [7:0]            BurstLast = 8'(BURST - 1);
  localparam logic [1:0]            TurnLast  = 2'(TURNAROUND - 1);

  state_e                state_q, state_d;
  dir_e                  last_dir_q, last_dir_d;
  dir_e                  target_q, target_d;
  dir_e                  grant_dir;
  logic [1:0]            turn_cnt_q, turn_cnt_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH-1:0] occ_q, occ_d;
  logic [FIFO_DEPTH-1:0] capacity_q;
  logic                  space_q, data_q;
  logic                  wr_ok, rd_ok;
  logic                  turn_entry;

  // Flags are registered, so an access this cycle can never overrun full/empty.
  assign wr_ok = wr_req & space_q;
  assign rd_ok = rd_req & data_q;

  // Arbitration, burst sequencing, strobes and pointer/occupancy next-state.
  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    target_d    = target_q;
    grant_dir   = DirWrite;
    turn_cnt_d  = turn_cnt_q;
    burst_cnt_d = burst_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    turn_entry  = 1'b0;
    wr_ack      = 1'b0;
    rd_ack      = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;

    unique case (state_q)
      StIdle: begin
        burst_cnt_d = '0;
        turn_cnt_d  = '0;
        if (wr_ok || rd_ok) begin
          // Both eligible: alternate away from the last served direction.
          if (wr_ok && rd_ok) begin
            grant_dir = (last_dir_q == DirRead) ? DirWrite : DirRead;
          end else begin
            grant_dir = wr_ok ? DirWrite : DirRead;
          end
          target_d = grant_dir;
          if ((grant_dir != last_dir_q) && (TURNAROUND != 0)) begin
            state_d    = StTurn;
            turn_entry = 1'b1;
          end else begin
            state_d = dir_state(grant_dir);
          end
        end
      end

      StTurn: begin
        // Requests are not re-sampled here; the burst state drops out if they vanished.
        if (turn_cnt_q == TurnLast) begin
          state_d    = dir_state(target_q);
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 2'd1;
        end
      end

      StWrite: begin
        if (wr_ok) begin
          wr_ack      = 1'b1;
          ram_en      = 1'b1;
          ram_we      = 1'b1;
          ram_addr    = RAM_DEPTH'(wr_ptr_q);
          wr_ptr_d    = wr_ptr_q + PtrOne;
          occ_d       = occ_q + PtrOne;
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
        if (!wr_ok || (burst_cnt_q == BurstLast)) begin
          state_d    = StIdle;
          last_dir_d = DirWrite;
        end
      end

      StRead: begin
        if (rd_ok) begin
          rd_ack      = 1'b1;
          ram_en      = 1'b1;
          ram_addr    = RAM_DEPTH'(rd_ptr_q);
          rd_ptr_d    = rd_ptr_q + PtrOne;
          occ_d       = occ_q - PtrOne;
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
        if (!rd_ok || (burst_cnt_q == BurstLast)) begin
          state_d    = StIdle;
          last_dir_d = DirRead;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State, pointers, occupancy and flags registered from next-state occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_dir_q  <= DirRead;
      target_q    <= DirWrite;
      turn_cnt_q  <= '0;
      burst_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      capacity_q  <= OccMax;
      space_q     <= 1'b1;
      data_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      target_q    <= target_d;
      turn_cnt_q  <= turn_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      capacity_q  <= OccMax - occ_d;
      space_q     <= (occ_d != OccMax);
      data_q      <= (occ_d != '0);
    end
  end

  assign capacity    = capacity_q;
  assign space_avail = space_q;
  assign data_avail  = data_q;

  // Read data appears on the SRAM bus READ_LAT cycles after the read is issued.
  nobl_delay_line #(
    .WIDTH(1),
    .DEPTH(READ_LAT)
  ) u_rd_valid_dly (
    .clk (clk),
    .rst (rst),
    .din (rd_ack),
    .dout(rd_valid)
  );

  // ZBT write data is driven two cycles after the write command.
  nobl_delay_line #(
    .WIDTH(1),
    .DEPTH(2)
  ) u_doe_dly (
    .clk (clk),
    .rst (rst),
    .din (ram_we),
    .dout(ram_doe)
  );

`ifdef SCHED_STATS_EN
  logic [15:0]           stat_turns_q;
  logic [FIFO_DEPTH-1:0] stat_maxocc_q;

  // Saturating TURN-entry count and occupancy high-water mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_turns_q  <= '0;
      stat_maxocc_q <= '0;
    end else begin
      if (turn_entry && (stat_turns_q != 16'hFFFF)) begin
        stat_turns_q <= stat_turns_q + 16'd1;
      end
      if (occ_d > stat_maxocc_q) begin
        stat_maxocc_q <= occ_d;
      end
    end
  end

  assign stat_turns  = stat_turns_q;
  assign stat_maxocc = stat_maxocc_q;
`else
  logic unused_turn_entry;
  assign unused_turn_entry = turn_entry;
`endif

endmodule

// File: tb/tb_nobl_rw_scheduler.sv
// Scoreboard bench for nobl_rw_scheduler: directed scenarios plus random requests.
module tb_nobl_rw_scheduler;

  localparam int RD     = 6;
  localparam int FD     = 4;
  localparam int MAXOCC = (1 << FD) - 1;
  localparam int BURST  = 8;
  localparam int TA     = 1;
  localparam int RL     = 2;

  logic          clk;
  logic          rst;
  logic          wr_req, rd_req;
  logic          wr_ack, rd_ack, rd_valid;
  logic [RD-1:0] ram_addr;
  logic          ram_we, ram_en, ram_doe;
  logic [FD-1:0] capacity;
  logic          space_avail, data_avail;
`ifdef SCHED_STATS_EN
  logic [15:0]   stat_turns;
  logic [FD-1:0] stat_maxocc;
`endif

  nobl_rw_scheduler #(
    .RAM_DEPTH (RD),
    .FIFO_DEPTH(FD),
    .BURST     (BURST),
    .TURNAROUND(TA),
    .READ_LAT  (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_en     (ram_en),
    .ram_doe    (ram_doe),
    .capacity   (capacity),
    .space_avail(space_avail),
    .data_avail (data_avail)
`ifdef SCHED_STATS_EN
    ,
    .stat_turns (stat_turns),
    .stat_maxocc(stat_maxocc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_min(input string nm, input int act, input int lo);
    total++;
    if (act < lo) begin
      bad++;
      $display("FAIL %s: got %0d expected at least %0d (t=%0t)", nm, act, lo, $time);
    end
  endtask

  task automatic check_max(input string nm, input int act, input int hi);
    total++;
    if (act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected at most %0d (t=%0t)", nm, act, hi, $time);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  int cyc     = 0;
  int n_wr    = 0;
  int n_rd    = 0;
  bit logging = 1'b0;
  int ack_log[$];
  int cap_log[$];
  int addr_log[$];

  int stored[$];   // SRAM addresses holding unread words, oldest first
  int due[$];      // cycles at which rd_valid must pulse
  int wptr;
  bit [1:0] we_hist;
  int prev_dir, prev_cyc, run_len;

  task automatic model_clear();
    stored.delete();
    due.delete();
    wptr     = 0;
    we_hist  = '0;
    prev_dir = 0;
    prev_cyc = 0;
    run_len  = 0;
  endtask

  task automatic track(input int d);
    if (d == prev_dir && prev_cyc == cyc - 1) begin
      run_len++;
    end else begin
      if (prev_dir != 0 && d != prev_dir) check_min("turn_gap", cyc - prev_cyc - 1, 1 + TA);
      run_len = 1;
    end
    check_max("burst_len", run_len, BURST);
    prev_dir = d;
    prev_cyc = cyc;
  endtask

  initial begin : monitor
    int sz;
    int exp_v;
    model_clear();
    forever begin
      @(negedge clk);
      cyc++;
      if (logging) begin
        ack_log.push_back((rd_valid ? 4 : 0) | (rd_ack ? 2 : 0) | (wr_ack ? 1 : 0));
        cap_log.push_back(int'(capacity));
        if (wr_ack || rd_ack) addr_log.push_back(int'(ram_addr));
      end
      if (rst) begin
        model_clear();
      end else begin
        sz = stored.size();
        check("capacity", int'(capacity), MAXOCC - sz);
        check("space_avail", int'(space_avail), int'(sz != MAXOCC));
        check("data_avail", int'(data_avail), int'(sz != 0));
        exp_v = 0;
        if (due.size() > 0 && due[0] == cyc) begin
          exp_v = 1;
          void'(due.pop_front());
        end
        check("rd_valid", int'(rd_valid), exp_v);
        check("ram_doe", int'(ram_doe), int'(we_hist[1]));
        we_hist = {we_hist[0], wr_ack};
        check("ram_en", int'(ram_en), int'(wr_ack | rd_ack));
        check("ram_we", int'(ram_we), int'(wr_ack));
        if (wr_ack && rd_ack) check("both_acks", 1, 0);
        if (wr_ack) begin
          n_wr++;
          check("wr_ack_without_req", int'(wr_req), 1);
          check_max("wr_ack_occ", sz, MAXOCC - 1);
          check("wr_addr", int'(ram_addr), wptr);
          stored.push_back(wptr);
          wptr = (wptr + 1) % (MAXOCC + 1);
          track(1);
        end else if (rd_ack) begin
          n_rd++;
          check("rd_ack_without_req", int'(rd_req), 1);
          check_min("rd_ack_occ", sz, 1);
          if (sz > 0) check("rd_addr", int'(ram_addr), stored.pop_front());
          due.push_back(cyc + RL);
          track(2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_log();
    ack_log.delete();
    cap_log.delete();
    addr_log.delete();
    logging = 1'b1;
  endtask

  // Issue exactly n writes, then let the scheduler settle back to idle.
  task automatic preload(input int n);
    int start;
    int guard;
    start  = n_wr;
    guard  = 0;
    wr_req = 1'b1;
    while (n_wr - start < n && guard < 100) begin
      tick();
      guard++;
    end
    wr_req = 1'b0;
    check("preload_count", n_wr - start, n);
    repeat (3) tick();
  endtask

  function automatic bit in_rng(input int i, input int lo, input int len);
    return (i >= lo) && (i < lo + len);
  endfunction

  // Alternating-burst timeline: grant cycle, TURN, burst, then IDLE+TURN before the other side.
  localparam int ALT_OFF = 1 + TA;
  localparam int PERIOD  = 2 * (BURST + 1 + TA);

  function automatic bit alt_rd(input int i);
    return (i >= ALT_OFF) && (((i - ALT_OFF) % PERIOD) < BURST);
  endfunction

  function automatic bit alt_wr(input int i);
    int p;
    if (i < ALT_OFF) return 1'b0;
    p = (i - ALT_OFF) % PERIOD;
    return in_rng(p, BURST + 1 + TA, BURST);
  endfunction

  initial begin : stimulus
    int exp_c;
    int n0;
    int guard;

    rst     = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state, and no access while only rd_req is asserted.
    check("rst_capacity", int'(capacity), MAXOCC);
    check("rst_space", int'(space_avail), 1);
    check("rst_data", int'(data_avail), 0);
    check("rst_en", int'(ram_en), 0);
    check("rst_we", int'(ram_we), 0);
    check("rst_doe", int'(ram_doe), 0);
    check("rst_valid", int'(rd_valid), 0);
    rd_req = 1'b1;
    start_log();
    repeat (6) tick();
    logging = 1'b0;
    check("rst_no_ack", ack_log.sum(), 0);
    rd_req = 1'b0;

    // Continuous writes until full: TURN first (reset last_dir is READ), 8, IDLE, 7.
    wr_req = 1'b1;
    start_log();
    repeat (22) tick();
    logging = 1'b0;
    check("fill_len", ack_log.size(), 22);
    for (int i = 0; i < ack_log.size(); i++) begin
      exp_c = (in_rng(i, 1 + TA, BURST) || in_rng(i, 2 + TA + BURST, MAXOCC - BURST)) ? 1 : 0;
      check($sformatf("fill_ack[%0d]", i), ack_log[i], exp_c);
    end
    check("fill_naddr", addr_log.size(), MAXOCC);
    for (int j = 0; j < addr_log.size(); j++) check($sformatf("fill_addr[%0d]", j), addr_log[j], j);
    check("full_capacity", int'(capacity), 0);
    check("full_space", int'(space_avail), 0);
    check("full_wr_ack", int'(wr_ack), 0);
    wr_req = 1'b0;

    // Five writes, then reads alone: one TURN, five reads, rd_valid two cycles later.
    do_reset();
    preload(5);
    check("five_capacity", int'(capacity), MAXOCC - 5);
    rd_req = 1'b1;
    start_log();
    repeat (12) tick();
    logging = 1'b0;
    for (int i = 0; i < ack_log.size(); i++) begin
      exp_c = (in_rng(i, 1 + TA, 5) ? 2 : 0) | (in_rng(i - RL, 1 + TA, 5) ? 4 : 0);
      check($sformatf("read5[%0d]", i), ack_log[i], exp_c);
    end
    check("read5_naddr", addr_log.size(), 5);
    for (int j = 0; j < addr_log.size(); j++) check($sformatf("read5_addr[%0d]", j), addr_log[j], j);
    check("read5_data_avail", int'(data_avail), 0);
    rd_req = 1'b0;
    repeat (2) tick();

    // Both sides requesting: alternating bursts with turnaround, occupancy periodic.
    preload(13);
    wr_req = 1'b1;
    rd_req = 1'b1;
    start_log();
    repeat (3 * PERIOD + ALT_OFF) tick();
    logging = 1'b0;
    for (int i = 0; i < ack_log.size(); i++) begin
      exp_c = (alt_wr(i) ? 1 : 0) | (alt_rd(i) ? 2 : 0) | (alt_rd(i - RL) ? 4 : 0);
      check($sformatf("alt[%0d]", i), ack_log[i], exp_c);
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("alt_cap[%0d]", k), cap_log[ALT_OFF + k * PERIOD], MAXOCC - 13);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (4) tick();

    // Reset during the third beat of a read burst.
    do_reset();
    preload(13);
    rd_req = 1'b1;
    n0     = n_rd;
    guard  = 0;
    while (n_rd - n0 < 2 && guard < 20) begin
      tick();
      guard++;
    end
    check("mid_reads_before", n_rd - n0, 2);
    check("mid_beat3_ack", int'(rd_ack), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rd_ack", int'(rd_ack), 0);
    check("mid_capacity", int'(capacity), MAXOCC);
    check("mid_data", int'(data_avail), 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mid_valid[%0d]", k), int'(rd_valid), 0);
      check($sformatf("mid_ack[%0d]", k), int'(rd_ack), 0);
      tick();
    end
    rd_req = 1'b0;

    // Random request traffic; the monitor model checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) wr_req = ~wr_req;
      if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
      tick();
    end
    check_min("rand_writes", n_wr, 100);
    check_min("rand_reads", n_rd, 100);
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
